// File: rtl/fetch_gshare_pred_pkg.sv
// Shared fetch-stage definitions: 2-bit branch counter encoding, default
// predictor geometry and the saturating counter update.
package fetch_gshare_pred_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    localparam int DEF_LOGINDEX = 10;
    localparam int DEF_HISTLEN  = 10;

    function automatic logic [1:0] ctrUpdate(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_gshare_pred_ram_dp.sv
// Dual-port RAM with combinational reads, synchronous writes and an
// asynchronous reset that loads every entry with INITVALUE.
module ram_dp #(
    parameter int                   ADDRWIDTH = 10,
    parameter int                   DATAWIDTH = 2,
    parameter logic [DATAWIDTH-1:0] INITVALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDRWIDTH-1:0] i_addr1,
    input  logic                 i_we1,
    input  logic [DATAWIDTH-1:0] i_wdata1,
    output logic [DATAWIDTH-1:0] o_rdata1,
    input  logic [ADDRWIDTH-1:0] i_addr2,
    input  logic                 i_we2,
    input  logic [DATAWIDTH-1:0] i_wdata2,
    output logic [DATAWIDTH-1:0] o_rdata2
);

    localparam int DEPTH = 1 << ADDRWIDTH;

    logic [DATAWIDTH-1:0] r_mem [DEPTH];

    // Port 2 is written last, so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INITVALUE;
            end
        end else begin
            if (i_we1) begin
                r_mem[i_addr1] <= i_wdata1;
            end
            if (i_we2) begin
                r_mem[i_addr2] <= i_wdata2;
            end
        end
    end

    assign o_rdata1 = r_mem[i_addr1];
    assign o_rdata2 = r_mem[i_addr2];

endmodule

// File: rtl/fetch_gshare_pred.sv
// Gshare direction predictor: PC xor speculative global history indexes a
// table of 2-bit counters; training is a registered read-modify-write.
module fetch_gshare_pred
    import fetch_gshare_pred_pkg::*;
#(
    parameter int LOGINDEX = DEF_LOGINDEX,
    parameter int HISTLEN  = DEF_HISTLEN,
    parameter int PCWIDTH  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lookup_valid_in,
    input  logic [PCWIDTH-1:0]  lookup_pc_in,
    output logic                pred_valid_out,
    output logic                pred_taken_out,
    output logic [LOGINDEX-1:0] pred_index_out,
    output logic [HISTLEN-1:0]  pred_ghr_out,
    input  logic                upd_valid_in,
    input  logic [LOGINDEX-1:0] upd_index_in,
    input  logic                upd_taken_in,
    input  logic                upd_mispredict_in,
    input  logic [HISTLEN-1:0]  upd_ghr_in
);

    logic [HISTLEN-1:0]  r_ghr;
    logic                r_pred_valid;
    logic                r_pred_taken;
    logic [LOGINDEX-1:0] r_pred_index;
    logic [HISTLEN-1:0]  r_pred_ghr;
    logic                r_upd_valid;
    logic                r_upd_taken;
    logic [LOGINDEX-1:0] r_upd_index;

    logic [HISTLEN-1:0]  w_ghr_eff;
    logic [LOGINDEX-1:0] w_ghr_ext;
    logic [LOGINDEX-1:0] w_idx;
    logic [1:0]          w_rdata1;
    logic [1:0]          w_rdata2;
    logic [1:0]          w_new_ctr;
    logic [1:0]          w_lookup_ctr;
    logic                w_repair;
    logic                w_lookup_fire;
    logic                w_unused_bits;

    assign w_unused_bits = ^{lookup_pc_in[PCWIDTH-1:LOGINDEX+2], lookup_pc_in[1:0],
                             upd_ghr_in[HISTLEN-1]};

    // The prediction on the outputs this cycle is folded into the history
    // immediately, so a back-to-back lookup already sees it.
    always_comb begin
        w_ghr_eff = r_pred_valid ? {r_ghr[HISTLEN-2:0], r_pred_taken} : r_ghr;
        w_ghr_ext = '0;
        w_ghr_ext[HISTLEN-1:0] = w_ghr_eff;
        w_idx = lookup_pc_in[LOGINDEX+1:2] ^ w_ghr_ext;
    end

    assign w_new_ctr     = ctrUpdate(w_rdata2, r_upd_taken);
    assign w_lookup_ctr  = (r_upd_valid && (r_upd_index == w_idx)) ? w_new_ctr : w_rdata1;
    assign w_repair      = upd_valid_in && upd_mispredict_in;
    assign w_lookup_fire = lookup_valid_in && !w_repair;

    ram_dp #(
        .ADDRWIDTH (LOGINDEX),
        .DATAWIDTH (2),
        .INITVALUE (CTR_WNT)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .i_addr1  (w_idx),
        .i_we1    (1'b0),
        .i_wdata1 (2'b00),
        .o_rdata1 (w_rdata1),
        .i_addr2  (r_upd_index),
        .i_we2    (r_upd_valid),
        .i_wdata2 (w_new_ctr),
        .o_rdata2 (w_rdata2)
    );

    // Repair restarts history from the checkpoint and squashes the lookup
    // issued in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_index <= '0;
            r_pred_ghr   <= '0;
            r_upd_valid  <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_upd_index  <= '0;
        end else begin
            r_ghr        <= w_repair ? {upd_ghr_in[HISTLEN-2:0], upd_taken_in} : w_ghr_eff;
            r_pred_valid <= w_lookup_fire;
            if (w_lookup_fire) begin
                r_pred_taken <= w_lookup_ctr[1];
                r_pred_index <= w_idx;
                r_pred_ghr   <= w_ghr_eff;
            end
            r_upd_valid <= upd_valid_in;
            if (upd_valid_in) begin
                r_upd_taken <= upd_taken_in;
                r_upd_index <= upd_index_in;
            end
        end
    end

    assign pred_valid_out = r_pred_valid;
    assign pred_taken_out = r_pred_taken;
    assign pred_index_out = r_pred_index;
    assign pred_ghr_out   = r_pred_ghr;

endmodule

// File: tb/tb_fetch_gshare_pred.sv
// Directed bench for fetch_gshare_pred: an abstract history/counter model is
// checked every cycle, plus hand-computed expectations per scenario.
module tb_fetch_gshare_pred;

    localparam int LOGINDEX = 10;
    localparam int HISTLEN  = 10;
    localparam int PCWIDTH  = 64;
    localparam int PHTSIZE  = 1 << LOGINDEX;
    localparam int HMASK    = (1 << HISTLEN) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                lookup_valid_in = 1'b0;
    logic [PCWIDTH-1:0]  lookup_pc_in = '0;
    logic                pred_valid_out;
    logic                pred_taken_out;
    logic [LOGINDEX-1:0] pred_index_out;
    logic [HISTLEN-1:0]  pred_ghr_out;
    logic                upd_valid_in = 1'b0;
    logic [LOGINDEX-1:0] upd_index_in = '0;
    logic                upd_taken_in = 1'b0;
    logic                upd_mispredict_in = 1'b0;
    logic [HISTLEN-1:0]  upd_ghr_in = '0;

    int nCompared = 0;
    int nMismatched = 0;
    bit checkEn = 1'b0;

    fetch_gshare_pred #(
        .LOGINDEX (LOGINDEX),
        .HISTLEN  (HISTLEN),
        .PCWIDTH  (PCWIDTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_valid_in   (lookup_valid_in),
        .lookup_pc_in      (lookup_pc_in),
        .pred_valid_out    (pred_valid_out),
        .pred_taken_out    (pred_taken_out),
        .pred_index_out    (pred_index_out),
        .pred_ghr_out      (pred_ghr_out),
        .upd_valid_in      (upd_valid_in),
        .upd_index_in      (upd_index_in),
        .upd_taken_in      (upd_taken_in),
        .upd_mispredict_in (upd_mispredict_in),
        .upd_ghr_in        (upd_ghr_in)
    );

    always #5 clk = ~clk;

    // Model: a trained counter counts for lookups from the following cycle;
    // history is a plain integer shifted by each presented prediction.
    int  mPht [PHTSIZE];
    int  mGhr;
    bit  pendValid;
    int  pendIdx;
    bit  pendTaken;
    bit  expValid;
    bit  expTaken;
    int  expIndex;
    int  expGhr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHTSIZE; i++) mPht[i] = 1;
            mGhr = 0; pendValid = 0; pendIdx = 0; pendTaken = 0;
            expValid = 0; expTaken = 0; expIndex = 0; expGhr = 0;
        end else begin
            int ghrNow;
            int idx;
            bit repair;
            if (pendValid) begin
                if (pendTaken) mPht[pendIdx] = (mPht[pendIdx] >= 3) ? 3 : mPht[pendIdx] + 1;
                else           mPht[pendIdx] = (mPht[pendIdx] <= 0) ? 0 : mPht[pendIdx] - 1;
            end
            pendValid = upd_valid_in;
            pendIdx   = int'(upd_index_in);
            pendTaken = upd_taken_in;
            repair = upd_valid_in && upd_mispredict_in;
            ghrNow = expValid ? (((mGhr * 2) + int'(expTaken)) & HMASK) : mGhr;
            if (lookup_valid_in && !repair) begin
                idx = (int'(lookup_pc_in / 4) % PHTSIZE) ^ ghrNow;
                expValid = 1;
                expTaken = (mPht[idx] >= 2);
                expIndex = idx;
                expGhr   = ghrNow;
            end else begin
                expValid = 0;
            end
            mGhr = repair ? (((int'(upd_ghr_in) * 2) + int'(upd_taken_in)) & HMASK) : ghrNow;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn && !reset) begin
            checkOutput("model.valid", 64'(pred_valid_out), 64'(expValid));
            if (expValid) begin
                checkOutput("model.taken", 64'(pred_taken_out), 64'(expTaken));
                checkOutput("model.index", 64'(pred_index_out), 64'(expIndex));
                checkOutput("model.ghr",   64'(pred_ghr_out),   64'(expGhr));
            end
        end
    end

    // Drives one cycle of inputs from a negedge, returns at the next negedge.
    task automatic applyStimulus(input bit lv, input logic [63:0] pc, input bit uv,
                                 input int ui, input bit ut, input bit um, input int ug);
        lookup_valid_in   = lv;
        lookup_pc_in      = pc;
        upd_valid_in      = uv;
        upd_index_in      = LOGINDEX'(ui);
        upd_taken_in      = ut;
        upd_mispredict_in = um;
        upd_ghr_in        = HISTLEN'(ug);
        @(negedge clk);
        lookup_valid_in   = 1'b0;
        upd_valid_in      = 1'b0;
        upd_mispredict_in = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] pc);
        applyStimulus(1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input int idx, input bit taken);
        applyStimulus(0, 64'h0, 1, idx, taken, 0, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        doReset();
        checkEn = 1'b1;
        checkOutput("reset.valid", 64'(pred_valid_out), 64'h0);
        checkOutput("reset.taken", 64'(pred_taken_out), 64'h0);
        checkOutput("reset.index", 64'(pred_index_out), 64'h0);
        checkOutput("reset.ghr",   64'(pred_ghr_out),   64'h0);

        // First lookup after reset, then a second one seeing an NT shift.
        lookup(64'h1000);
        checkOutput("first.valid", 64'(pred_valid_out), 64'h1);
        checkOutput("first.taken", 64'(pred_taken_out), 64'h0);
        checkOutput("first.index", 64'(pred_index_out), 64'h000);
        checkOutput("first.ghr",   64'(pred_ghr_out),   64'h000);
        lookup(64'h1000);
        checkOutput("second.ghr",  64'(pred_ghr_out),   64'h000);
        applyStimulus(0, 64'h0, 0, 0, 0, 0, 0);
        checkOutput("idle.valid",  64'(pred_valid_out), 64'h0);

        // Counter saturation on index 5, pc chosen to track the shifting GHR.
        doReset();
        train(5, 1);
        train(5, 1);
        lookup(64'h14);
        checkOutput("sat.ctr2.taken", 64'(pred_taken_out), 64'h1);
        checkOutput("sat.ctr2.index", 64'(pred_index_out), 64'h005);
        train(5, 1);
        train(5, 0);
        lookup(64'h10);
        checkOutput("sat.ctr2b.taken", 64'(pred_taken_out), 64'h1);
        checkOutput("sat.ctr2b.ghr",   64'(pred_ghr_out),   64'h001);
        train(5, 0);
        lookup(64'h18);
        checkOutput("sat.ctr1.taken", 64'(pred_taken_out), 64'h0);
        checkOutput("sat.ctr1.index", 64'(pred_index_out), 64'h005);
        train(5, 0);
        train(5, 0);
        train(5, 0);
        train(5, 1);
        lookup(64'h0C);
        checkOutput("sat.low.taken", 64'(pred_taken_out), 64'h0);
        checkOutput("sat.low.ghr",   64'(pred_ghr_out),   64'h006);

        // Repair while a prediction is presented and a lookup is issued.
        doReset();
        lookup(64'h1000);
        applyStimulus(1, 64'h1000, 1, 0, 1, 1, 3);
        checkOutput("repair.squash", 64'(pred_valid_out), 64'h0);
        lookup(64'h1000);
        checkOutput("repair.index", 64'(pred_index_out), 64'h007);
        checkOutput("repair.ghr",   64'(pred_ghr_out),   64'h007);

        // Bypass of the pending write to index 9.
        doReset();
        train(9, 1);
        lookup(64'h24);
        checkOutput("bypass.taken", 64'(pred_taken_out), 64'h1);
        checkOutput("bypass.index", 64'(pred_index_out), 64'h009);

        // Speculative history across back-to-back lookups.
        doReset();
        train(0, 1);
        train(0, 1);
        train(0, 1);
        lookup(64'h1000);
        checkOutput("spec.first.taken", 64'(pred_taken_out), 64'h1);
        checkOutput("spec.first.index", 64'(pred_index_out), 64'h000);
        lookup(64'h1000);
        checkOutput("spec.second.ghr",   64'(pred_ghr_out),   64'h001);
        checkOutput("spec.second.index", 64'(pred_index_out), 64'h001);

        // Asynchronous reset while a write to index 3 is pending.
        doReset();
        applyStimulus(1, 64'h0C, 1, 3, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset.valid", 64'(pred_valid_out), 64'h0);
        checkOutput("areset.taken", 64'(pred_taken_out), 64'h0);
        checkOutput("areset.index", 64'(pred_index_out), 64'h0);
        checkOutput("areset.ghr",   64'(pred_ghr_out),   64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        lookup(64'h0C);
        checkOutput("areset.pht3.taken", 64'(pred_taken_out), 64'h0);
        checkOutput("areset.pht3.index", 64'(pred_index_out), 64'h003);
        train(3, 1);
        lookup(64'h0C ^ 64'h0);
        checkOutput("areset.pht3.trained", 64'(pred_taken_out), 64'h1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
